// File: rtl/sysreg_bank_pkg.sv
// -----------------------------------------------------------------------------
// sysreg_bank_pkg
// Shared constants and types for the second-generation system register bank:
// register offsets (decoded from a[4:0]), LOG_CTRL / LOG_STATUS bit positions,
// the default read value and the write-log entry layout.
// -----------------------------------------------------------------------------
package sysreg_bank_pkg;

  // Register offsets within the 32-byte decode window
  localparam logic [4:0] OFF_ID0          = 5'h00;
  localparam logic [4:0] OFF_ID1          = 5'h01;
  localparam logic [4:0] OFF_VER          = 5'h02;
  localparam logic [4:0] OFF_LOG_STATUS   = 5'h03;
  localparam logic [4:0] OFF_LOG_ADDR     = 5'h04;
  localparam logic [4:0] OFF_LOG_DATA     = 5'h05;
  localparam logic [4:0] OFF_LOG_CTRL     = 5'h06;
  localparam logic [4:0] OFF_SCRATCH_BASE = 5'h08;

  // LOG_CTRL bits (CLR_FIFO and CLR_OVF are write-only actions)
  localparam int CLR_FIFO = 0;
  localparam int CLR_OVF  = 1;
  localparam int LOG_EN   = 2;

  // LOG_STATUS = {overflow, empty, head_a8, count[4:0]}
  localparam int ST_OVF     = 7;
  localparam int ST_EMPTY   = 6;
  localparam int ST_HEAD_A8 = 5;
  localparam int ST_COUNT_W = 5;

  localparam logic [7:0] READ_DEFAULT = 8'hFF;

  // One logged bus write: full 9-bit address plus the written byte (17 bits)
  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } log_entry_t;

endpackage

// File: rtl/sysreg_bank_if.sv
// -----------------------------------------------------------------------------
// sysreg_bank_if
// Strobe-based internal register bus.
//   a            : register address (9 bits, only a[4:0] decoded)
//   d_d          : write data
//   d_q          : registered read data (driven by the register bank)
//   read_strobe  : one-cycle read request
//   write_strobe : one-cycle write request, may coincide with read_strobe
// -----------------------------------------------------------------------------
interface sysreg_bank_if;
  logic [8:0] a;
  logic [7:0] d_d;
  logic [7:0] d_q;
  logic       read_strobe;
  logic       write_strobe;

  modport master (
    output a,
    output d_d,
    output read_strobe,
    output write_strobe,
    input  d_q
  );

  modport slave (
    input  a,
    input  d_d,
    input  read_strobe,
    input  write_strobe,
    output d_q
  );
endinterface

// File: rtl/sysreg_bank_write_log.sv
// -----------------------------------------------------------------------------
// sysreg_bank_write_log
// Synchronous FIFO of recent bus writes (17-bit entries, LOG_DEPTH deep).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push         : append push_entry (dropped when full unless popping too)
//   pop          : remove head entry (no-op when empty)
//   clear        : empty the FIFO; overrides push and pop
//   push_entry   : entry to append
//   head         : current oldest entry (undefined content when empty)
//   count        : number of valid entries
//   full, empty  : occupancy flags
//   push_drop    : one-cycle pulse when a push was discarded for lack of room
// -----------------------------------------------------------------------------
module sysreg_bank_write_log
  import sysreg_bank_pkg::*;
#(
  parameter int LOG_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  log_entry_t                   push_entry,
  output log_entry_t                   head,
  output logic [$clog2(LOG_DEPTH):0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         push_drop
);

  localparam int AW = $clog2(LOG_DEPTH);
  localparam int CW = AW + 1;

  log_entry_t    mem [LOG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(LOG_DEPTH));

  // A pop on a full FIFO frees the slot the simultaneous push needs
  assign pop_ok    = pop & ~empty & ~clear;
  assign push_ok   = push & ~clear & (~full | pop_ok);
  assign push_drop = push & ~clear & full & ~pop_ok;

  assign head = mem[rd_ptr];

  // Pointers wrap naturally because LOG_DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (!push_ok && pop_ok) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: entries are only visible once count covers them
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/sysreg_bank.sv
// -----------------------------------------------------------------------------
// sysreg_bank
// System register bank: ID/version bytes, NUM_SCRATCH scratch registers and a
// write-history log that firmware can peek/pop through LOG_ADDR/LOG_DATA.
// Ports:
//   clk     : system clock (rising edge)
//   reset_n : asynchronous active-low reset
//   bus     : register bus slave (a, d_d, d_q, read_strobe, write_strobe)
// d_q is registered: it captures the selected register on the edge where
// read_strobe is high and holds otherwise.
// -----------------------------------------------------------------------------
module sysreg_bank
  import sysreg_bank_pkg::*;
#(
  parameter logic [7:0] ID0         = 8'h42,
  parameter logic [7:0] ID1         = 8'h73,
  parameter logic [7:0] VERSION     = 8'h02,
  parameter int         NUM_SCRATCH = 4,
  parameter int         LOG_DEPTH   = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  sysreg_bank_if.slave bus
);

  localparam int CW = $clog2(LOG_DEPTH) + 1;

  logic [4:0]  off;
  logic [4:0]  scr_idx;
  logic [7:0]  scratch [NUM_SCRATCH];
  logic        log_en;
  logic        overflow;
  logic        ctrl_wr;

  logic        log_push;
  logic        log_pop;
  logic        log_clear;
  log_entry_t  log_in;
  log_entry_t  log_head;
  logic [CW-1:0] log_count;
  logic        log_full;
  logic        log_empty;
  logic        log_drop;

  logic [7:0]  rd_data;
  logic [7:0]  status;

  assign off     = bus.a[4:0];
  // Offsets below the scratch base wrap to large indices and never match
  assign scr_idx = off - OFF_SCRATCH_BASE;
  assign ctrl_wr = bus.write_strobe && (off == OFF_LOG_CTRL);

  // LOG_CTRL writes are never logged, so clear and push cannot collide
  assign log_push  = bus.write_strobe && log_en && (off != OFF_LOG_CTRL);
  assign log_pop   = bus.read_strobe && (off == OFF_LOG_DATA);
  assign log_clear = ctrl_wr && bus.d_d[CLR_FIFO];
  assign log_in    = '{addr: bus.a, data: bus.d_d};

  sysreg_bank_write_log #(
    .LOG_DEPTH (LOG_DEPTH)
  ) u_write_log (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (log_push),
    .pop        (log_pop),
    .clear      (log_clear),
    .push_entry (log_in),
    .head       (log_head),
    .count      (log_count),
    .full       (log_full),
    .empty      (log_empty),
    .push_drop  (log_drop)
  );

  // Control state: log enable and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      log_en   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr) log_en <= bus.d_d[LOG_EN];
      if (ctrl_wr && bus.d_d[CLR_OVF]) overflow <= 1'b0;
      else if (log_drop)               overflow <= 1'b1;
    end
  end

  // Scratch registers
  for (genvar n = 0; n < NUM_SCRATCH; n++) begin : g_scratch
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        scratch[n] <= 8'h00;
      end else if (bus.write_strobe && (scr_idx == 5'(n))) begin
        scratch[n] <= bus.d_d;
      end
    end
  end

  always_comb begin
    status                          = 8'h00;
    status[ST_OVF]                  = overflow;
    status[ST_EMPTY]                = log_empty;
    status[ST_HEAD_A8]              = log_empty ? 1'b0 : log_head.addr[8];
    status[ST_COUNT_W-1:0]          = ST_COUNT_W'(log_count);
  end

  // Read mux; the log head shown is always the pre-pop / pre-clear value
  always_comb begin
    rd_data = READ_DEFAULT;
    case (off)
      OFF_ID0:        rd_data = ID0;
      OFF_ID1:        rd_data = ID1;
      OFF_VER:        rd_data = VERSION;
      OFF_LOG_STATUS: rd_data = status;
      OFF_LOG_ADDR:   rd_data = log_empty ? READ_DEFAULT : log_head.addr[7:0];
      OFF_LOG_DATA:   rd_data = log_empty ? READ_DEFAULT : log_head.data;
      OFF_LOG_CTRL: begin
        rd_data         = 8'h00;
        rd_data[LOG_EN] = log_en;
      end
      default: begin
        for (int n = 0; n < NUM_SCRATCH; n++) begin
          if (scr_idx == 5'(n)) rd_data = scratch[n];
        end
      end
    endcase
  end

  // Read data register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.d_q <= READ_DEFAULT;
    end else if (bus.read_strobe) begin
      bus.d_q <= rd_data;
    end
  end

endmodule
